// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Holds the FSM state encoding, XLEN and the NOP instruction word.
package imem_pkg;

  localparam int          XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response handshake bundle for imem_responder.
// master = fetch unit side, slave = responder side.
interface imem_responder_if;
  import imem_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_instr;
  logic            rsp_fault;

  modport master (
    output req_valid,
    output req_addr,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_instr,
    input  rsp_fault
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_instr,
    output rsp_fault
  );

endinterface

// File: rtl/imem_array.sv
// Instruction word storage: one registered read port, one write port.
// Read and write on the same edge to the same word return the old word.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rd_en,
  input  logic [AW-1:0]   rd_idx,
  output logic [XLEN-1:0] rd_data,
  input  logic            we,
  input  logic [AW-1:0]   wr_idx,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[wr_idx] <= wr_data;
    if (rd_en)
      rd_data <= mem[rd_idx];
  end

endmodule

// File: rtl/imem_responder.sv
// Single-outstanding instruction fetch responder with fixed LATENCY.
// Define IMEM_RESPONDER_FAULT_EN for misaligned/out-of-range faults.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 1
) (
  input  logic            clk,
  input  logic            Reset_n,
  imem_responder_if.slave bus,
  input  logic            ld_en,
  input  logic [XLEN-1:0] ld_addr,
  input  logic [XLEN-1:0] ld_data
);

  localparam int AW = $clog2(DEPTH);

  state_t          state;
  logic [2:0]      cnt;
  logic            fault_q;
  logic [XLEN-1:0] rd_data;
  logic            accept;
  logic            req_bad;
  logic            ld_ok;
  logic            unused_ld;

  assign bus.req_ready = (state == IDLE) ||
                         (state == RESP && bus.rsp_ready);
  assign accept = bus.req_valid && bus.req_ready;

`ifdef IMEM_RESPONDER_FAULT_EN
  assign req_bad = (|bus.req_addr[XLEN-1:AW+2]) |
                   (|bus.req_addr[1:0]);
  assign ld_ok = ld_en & ~(|ld_addr[XLEN-1:AW+2]);
  assign unused_ld = ^ld_addr[1:0];
`else
  assign req_bad = 1'b0;
  assign ld_ok = ld_en;
  assign unused_ld = ^{bus.req_addr[XLEN-1:AW+2],
                       bus.req_addr[1:0],
                       ld_addr[XLEN-1:AW+2],
                       ld_addr[1:0]};
`endif

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .rd_en   (accept),
    .rd_idx  (bus.req_addr[AW+1:2]),
    .rd_data (rd_data),
    .we      (ld_ok),
    .wr_idx  (ld_addr[AW+1:2]),
    .wr_data (ld_data)
  );

  // A new accept overrides the per-state transition below.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      fault_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        BUSY: begin
          if (cnt == 3'd1) begin
            state <= RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready && !bus.req_valid)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (accept) begin
        fault_q <= req_bad;
        state   <= (LATENCY == 1) ? RESP : BUSY;
        cnt     <= 3'(LATENCY - 1);
      end
    end
  end

  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_fault = bus.rsp_valid & fault_q;
  assign bus.rsp_instr = !bus.rsp_valid ? '0 :
                         fault_q        ? NOP :
                                          rd_data;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: LATENCY=1 and LATENCY=3 copies.
// Directed fetches push expectations; a negedge monitor checks them.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int DEPTH = 16;
  localparam int L0    = 1;
  localparam int L1    = 3;

  typedef struct packed {
    logic [31:0] instr;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic Reset_n;

  logic [1:0]       req_valid, rsp_ready, ld_en;
  logic [1:0][31:0] req_addr, ld_addr, ld_data;
  logic [1:0]       req_ready, rsp_valid, rsp_fault;
  logic [1:0][31:0] rsp_instr;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q [2][$];
  int   acc_q [2][$];
  bit   presented [2];

  imem_responder_if b0 ();
  imem_responder_if b1 ();

  assign b0.req_valid = req_valid[0];
  assign b0.req_addr  = req_addr[0];
  assign b0.rsp_ready = rsp_ready[0];
  assign req_ready[0] = b0.req_ready;
  assign rsp_valid[0] = b0.rsp_valid;
  assign rsp_instr[0] = b0.rsp_instr;
  assign rsp_fault[0] = b0.rsp_fault;

  assign b1.req_valid = req_valid[1];
  assign b1.req_addr  = req_addr[1];
  assign b1.rsp_ready = rsp_ready[1];
  assign req_ready[1] = b1.req_ready;
  assign rsp_valid[1] = b1.rsp_valid;
  assign rsp_instr[1] = b1.rsp_instr;
  assign rsp_fault[1] = b1.rsp_fault;

  imem_responder #(.DEPTH(DEPTH), .LATENCY(L0)) dut0 (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (b0),
    .ld_en   (ld_en[0]),
    .ld_addr (ld_addr[0]),
    .ld_data (ld_data[0])
  );

  imem_responder #(.DEPTH(DEPTH), .LATENCY(L1)) dut1 (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (b1),
    .ld_en   (ld_en[1]),
    .ld_addr (ld_addr[1]),
    .ld_data (ld_data[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic load(input int d, input logic [31:0] a,
                      input logic [31:0] v);
    ld_en[d]   = 1'b1;
    ld_addr[d] = a;
    ld_data[d] = v;
    @(posedge clk);
    #1;
    ld_en[d] = 1'b0;
  endtask

  task automatic fetch(input int d, input logic [31:0] a,
                       input logic [31:0] ins, input logic f);
    exp_t e;
    bit   ok;
    e.instr = ins;
    e.fault = f;
    ok = 1'b0;
    req_valid[d] = 1'b1;
    req_addr[d]  = a;
    exp_q[d].push_back(e);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[d]) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL dut%0d req_timeout: req_ready 0, required 1", d);
    end
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    for (int i = 0; i < 50 && exp_q[d].size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk($sformatf("dut%0d drain", d), exp_q[d].size(), 0);
  endtask

  initial begin : monitor
    exp_t e;
    int   a;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (!Reset_n) begin
          acc_q[d].delete();
          presented[d] = 1'b0;
        end else begin
          if (!rsp_valid[d]) begin
            chk($sformatf("dut%0d idle_instr", d), rsp_instr[d], 0);
            chk($sformatf("dut%0d idle_fault", d), rsp_fault[d], 0);
          end else begin
            chk($sformatf("dut%0d resp_req_ready", d),
                req_ready[d], rsp_ready[d]);
            if (!presented[d]) begin
              presented[d] = 1'b1;
              if (acc_q[d].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut%0d latency: no accept, required one", d);
              end else begin
                a = acc_q[d].pop_front();
                chk($sformatf("dut%0d latency", d), 32'(cyc + 1 - a),
                    (d == 0) ? L0 : L1);
              end
            end
            if (exp_q[d].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL dut%0d unexpected_rsp: got %h, required none",
                       d, rsp_instr[d]);
            end else begin
              e = exp_q[d][0];
              chk($sformatf("dut%0d instr", d), rsp_instr[d], e.instr);
              chk($sformatf("dut%0d fault", d), rsp_fault[d], e.fault);
              if (rsp_ready[d]) begin
                void'(exp_q[d].pop_front());
                presented[d] = 1'b0;
              end
            end
          end
          if (req_valid[d] && req_ready[d])
            acc_q[d].push_back(cyc + 1);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit hit, required finish");
    $fatal(1);
  end

  initial begin : stim
    Reset_n   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    rsp_ready = 2'b11;
    ld_en     = '0;
    ld_addr   = '0;
    ld_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst rsp_valid", rsp_valid, 2'b00);
    chk("rst rsp_instr0", rsp_instr[0], 0);
    Reset_n = 1'b1;
    #1;
    chk("post_rst req_ready", req_ready, 2'b11);
    @(posedge clk);
    #1;

    load(0, 32'h0, 32'h0050_0093);
    load(0, 32'h4, 32'h0010_0113);
    load(0, 32'h8, 32'h0020_0193);
    load(1, 32'h0, 32'h0050_0093);
    load(1, 32'h4, 32'h0010_0113);

    fetch(0, 32'h0, 32'h0050_0093, 1'b0);
    drain(0);

    fetch(0, 32'h4, 32'h0010_0113, 1'b0);
    fetch(0, 32'h8, 32'h0020_0193, 1'b0);

    ld_en[0]   = 1'b1;
    ld_addr[0] = 32'h8;
    ld_data[0] = 32'h0030_0193;
    fetch(0, 32'h8, 32'h0020_0193, 1'b0);
    ld_en[0] = 1'b0;
    fetch(0, 32'h8, 32'h0030_0193, 1'b0);
    drain(0);

`ifdef IMEM_RESPONDER_FAULT_EN
    fetch(0, 32'h6, NOP, 1'b1);
    fetch(0, 32'h40, NOP, 1'b1);
    drain(0);
    load(0, 32'h40, 32'hdead_beef);
    fetch(0, 32'h0, 32'h0050_0093, 1'b0);
`else
    fetch(0, 32'h6, 32'h0010_0113, 1'b0);
    fetch(0, 32'h40, 32'h0050_0093, 1'b0);
    drain(0);
    load(0, 32'h4c, 32'h0040_0213);
    fetch(0, 32'hc, 32'h0040_0213, 1'b0);
`endif
    drain(0);

    rsp_ready[1] = 1'b0;
    fetch(1, 32'h0, 32'h0050_0093, 1'b0);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("stall req_ready", req_ready[1], 0);
    end
    @(posedge clk);
    #1;
    rsp_ready[1] = 1'b1;
    drain(1);

    fetch(1, 32'h4, 32'h0010_0113, 1'b0);
    fetch(1, 32'h0, 32'h0050_0093, 1'b0);
    drain(1);

    req_valid[1] = 1'b1;
    req_addr[1]  = 32'h4;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    chk("busy req_ready", req_ready[1], 0);
    Reset_n = 1'b0;
    #1;
    chk("async rsp_valid", rsp_valid[1], 0);
    chk("async req_ready", req_ready[1], 1);
    repeat (2) @(posedge clk);
    #1;
    Reset_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("after_rst req_ready", req_ready[1], 1);
    chk("after_rst rsp_valid", rsp_valid[1], 0);

    fetch(1, 32'h0, 32'h0050_0093, 1'b0);
    drain(1);
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errors);
    $finish;
  end

endmodule
